// File: rtl/data_mem_unit.sv
// Data-memory unit: word RAM behind a valid/ready request port with fixed access latency.
// Optional macro DMEM_RANGE_CHK_EN flags accesses with Addr >= DEPTH via Mem_err instead of wrapping.
module data_mem_unit #(
  parameter int unsigned N     = 16,
  parameter int unsigned A     = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         M_req,
  input  logic         M_we,
  input  logic [A-1:0] Addr,
  input  logic [N-1:0] Data_write,
  output logic         M_ready,
  output logic [N-1:0] Data_out,
  output logic         Data_valid,
  output logic         Wr_done,
  output logic         Mem_err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [A-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          wdone_q, wdone_d;

  logic [N-1:0]  mem_q [DEPTH];
  logic [31:0]   addr_ext_c;
  logic [IW-1:0] idx_c;
  logic          mem_wen_c;

`ifdef DMEM_RANGE_CHK_EN
  logic          merr_q, merr_d;
  logic          in_range_c;
  assign in_range_c = (addr_ext_c < 32'(DEPTH));
`endif

  // RAM index is the captured address modulo DEPTH
  assign addr_ext_c = 32'(addr_q);
  assign idx_c      = IW'(addr_ext_c % 32'(DEPTH));

  // Next-state and response logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    wdone_d   = 1'b0;
    mem_wen_c = 1'b0;
`ifdef DMEM_RANGE_CHK_EN
    merr_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (ready_q && M_req) begin
          we_d    = M_we;
          addr_d  = Addr;
          wdata_d = Data_write;
          cnt_d   = CW'(LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
`ifdef DMEM_RANGE_CHK_EN
          if (!in_range_c) begin
            merr_d = 1'b1;
            if (!we_q) begin
              dvalid_d = 1'b1;
              dout_d   = '0;
            end
          end else
`endif
          if (we_q) begin
            mem_wen_c = 1'b1;
            wdone_d   = 1'b1;
          end else begin
            dvalid_d = 1'b1;
            dout_d   = mem_q[idx_c];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      wdone_q  <= wdone_d;
    end
  end

  // RAM contents survive reset; a store pending at a reset edge is dropped
  always_ff @(posedge clk) begin
    if (mem_wen_c && !rst) begin
      mem_q[idx_c] <= wdata_q;
    end
  end

`ifdef DMEM_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      merr_q <= 1'b0;
    end else begin
      merr_q <= merr_d;
    end
  end
  assign Mem_err = merr_q;
`else
  assign Mem_err = 1'b0;
`endif

  assign M_ready    = ready_q;
  assign Data_out   = dout_q;
  assign Data_valid = dvalid_q;
  assign Wr_done    = wdone_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table on a LAT=2/DEPTH=200 instance plus
// hand sequences for busy drops, reset abort and a LAT=1/2/4 latency sweep.
module tb_data_mem_unit;

  localparam int unsigned N = 16;
  localparam int unsigned A = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic         m_we;
  logic [A-1:0] addr;
  logic [N-1:0] wdata;

  logic         rdy1, dv1, wd1, me1;
  logic         rdy2, dv2, wd2, me2;
  logic         rdy4, dv4, wd4, me4;
  logic [N-1:0] do1, do2, do4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.N(N), .A(A), .DEPTH(200), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .M_req(m_req), .M_we(m_we), .Addr(addr), .Data_write(wdata),
    .M_ready(rdy2), .Data_out(do2), .Data_valid(dv2), .Wr_done(wd2), .Mem_err(me2)
  );

  data_mem_unit #(.N(N), .A(A), .DEPTH(256), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .M_req(m_req), .M_we(m_we), .Addr(addr), .Data_write(wdata),
    .M_ready(rdy1), .Data_out(do1), .Data_valid(dv1), .Wr_done(wd1), .Mem_err(me1)
  );

  data_mem_unit #(.N(N), .A(A), .DEPTH(256), .LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .M_req(m_req), .M_we(m_we), .Addr(addr), .Data_write(wdata),
    .M_ready(rdy4), .Data_out(do4), .Data_valid(dv4), .Wr_done(wd4), .Mem_err(me4)
  );

  typedef struct {
    logic         we;
    logic [A-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] exp_dout;
    logic         exp_valid;
    logic         exp_wr;
    logic         exp_err;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic we, input logic [A-1:0] a, input logic [N-1:0] d,
                              input logic [N-1:0] ed, input logic v, input logic w, input logic e);
    vec_t r;
    r.we = we; r.addr = a; r.wdata = d; r.exp_dout = ed;
    r.exp_valid = v; r.exp_wr = w; r.exp_err = e;
    return r;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on u_lat2 and check its response; returns in the response cycle
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic seen;
    check_bit({tag, " ready"}, rdy2, 1'b1);
    m_req = 1'b1; m_we = v.we; addr = v.addr; wdata = v.wdata;
    tick();
    m_req = 1'b0;
    check_bit({tag, " busy"}, rdy2, 1'b0);
    check_word({tag, " pulses clear"}, 32'({dv2, wd2, me2}), 32'd0);
    lat  = 0;
    seen = 1'b0;
    while (seen !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      seen = dv2 | wd2 | me2;
    end
    check_word({tag, " latency"}, 32'(lat), 32'd2);
    check_bit({tag, " valid"}, dv2, v.exp_valid);
    check_bit({tag, " wr_done"}, wd2, v.exp_wr);
    check_bit({tag, " mem_err"}, me2, v.exp_err);
    check_word({tag, " data_out"}, 32'(do2), 32'(v.exp_dout));
    check_bit({tag, " ready back"}, rdy2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, f2, f4, b1, b2, b4, c1, c2, c4;

    vecs[0]  = mk(1'b1, 8'd5,   16'd30,  16'd0,   1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 8'd5,   16'd0,   16'd30,  1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 8'd1,   16'd10,  16'd30,  1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 8'd2,   16'd20,  16'd30,  1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 8'd1,   16'd0,   16'd10,  1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 8'd2,   16'd0,   16'd20,  1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 8'd3,   16'd33,  16'd20,  1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b1, 8'd50,  16'd123, 16'd20,  1'b0, 1'b1, 1'b0);
`ifdef DMEM_RANGE_CHK_EN
    vecs[8]  = mk(1'b1, 8'd250, 16'd7,   16'd20,  1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 8'd250, 16'd0,   16'd0,   1'b1, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 8'd50,  16'd0,   16'd123, 1'b1, 1'b0, 1'b0);
`else
    vecs[8]  = mk(1'b1, 8'd250, 16'd7,   16'd20,  1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 8'd250, 16'd0,   16'd7,   1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 8'd50,  16'd0,   16'd7,   1'b1, 1'b0, 1'b0);
`endif
    vecs[11] = mk(1'b0, 8'd2,   16'd0,   16'd20,  1'b1, 1'b0, 1'b0);

    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    check_bit("reset ready", rdy2, 1'b0);
    check_word("reset data_out", 32'(do2), 32'd0);
    check_word("reset pulses", 32'({dv2, wd2, me2}), 32'd0);
    check_bit("reset ready lat1", rdy1, 1'b0);
    check_bit("reset ready lat4", rdy4, 1'b0);

    // A request during reset must not be taken
    m_req = 1'b1; m_we = 1'b1; addr = 8'd5; wdata = 16'hDEAD;
    tick();
    m_req = 1'b0;
    check_bit("reset req ready", rdy2, 1'b0);
    rst = 1'b0;
    tick();
    check_bit("release ready", rdy2, 1'b1);
    check_word("release pulses", 32'({dv2, wd2, me2}), 32'd0);

    // Table vectors, each issued in the previous response cycle (no bubble)
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Store to Addr 1 while busy with a load of Addr 1 is dropped
    m_req = 1'b1; m_we = 1'b0; addr = 8'd1; wdata = '0;
    tick();
    m_we = 1'b1; wdata = 16'd99;
    tick();
    check_bit("busy drop mid", dv2, 1'b0);
    tick();
    m_req = 1'b0;
    check_bit("busy drop valid", dv2, 1'b1);
    check_word("busy drop data", 32'(do2), 32'd10);
    check_bit("busy drop no wr", wd2, 1'b0);
    run_vec(mk(1'b0, 8'd1, 16'd0, 16'd10, 1'b1, 1'b0, 1'b0), "busy reread");

    // Reset one cycle after a store is accepted aborts it
    m_req = 1'b1; m_we = 1'b1; addr = 8'd3; wdata = 16'd55;
    tick();
    m_req = 1'b0;
    rst = 1'b1;
    tick();
    check_bit("abort wr_done", wd2, 1'b0);
    check_word("abort data_out", 32'(do2), 32'd0);
    check_bit("abort ready", rdy2, 1'b0);
    rst = 1'b0;
    tick();
    check_bit("abort ready back", rdy2, 1'b1);
    check_word("abort late pulses", 32'({dv2, wd2, me2}), 32'd0);
    run_vec(mk(1'b0, 8'd3, 16'd0, 16'd33, 1'b1, 1'b0, 1'b0), "abort reread");

    // Latency sweep across LAT=1,2,4 instances from a common idle point
    repeat (6) tick();
    check_word("sweep idle", 32'({rdy1, rdy2, rdy4}), 32'd7);
    m_req = 1'b1; m_we = 1'b0; addr = 8'd5;
    tick();
    m_req = 1'b0;
    f1 = -1; f2 = -1; f4 = -1; b1 = 0; b2 = 0; b4 = 0; c1 = 0; c2 = 0; c4 = 0;
    for (int k = 0; k <= 8; k++) begin
      if (rdy1 !== 1'b1) b1++;
      if (rdy2 !== 1'b1) b2++;
      if (rdy4 !== 1'b1) b4++;
      if (dv1 === 1'b1) begin c1++; if (f1 < 0) f1 = k; end
      if (dv2 === 1'b1) begin c2++; if (f2 < 0) f2 = k; end
      if (dv4 === 1'b1) begin c4++; if (f4 < 0) f4 = k; end
      if (dv4 === 1'b1) check_word("sweep lat4 data", 32'(do4), 32'd30);
      if (dv1 === 1'b1) check_word("sweep lat1 data", 32'(do1), 32'd30);
      tick();
    end
    check_word("sweep lat1 edge", 32'(f1), 32'd1);
    check_word("sweep lat2 edge", 32'(f2), 32'd2);
    check_word("sweep lat4 edge", 32'(f4), 32'd4);
    check_word("sweep lat1 busy", 32'(b1), 32'd1);
    check_word("sweep lat2 busy", 32'(b2), 32'd2);
    check_word("sweep lat4 busy", 32'(b4), 32'd4);
    check_word("sweep pulse count", 32'(c1 + c2 + c4), 32'd3);
    check_word("sweep lat2 data", 32'(do2), 32'd30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
